mul_result_pack: RTL and testbench

MUL_RESULT_PACK -- requirements
Module: mul_result_pack

---
 rtl/fp_mul_pkg.sv | 21 ++
 rtl/rne_round.sv | 37 +++
 rtl/mul_result_pack.sv | 162 ++++++++++++++++
 tb/tb_mul_result_pack.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg
// Shared constants for the floating-point multiplier result stage.
//   EXP_W / FRAC_W  : IEEE-754 single-precision field widths
//   QNAN            : canonical quiet NaN returned for invalid operations
//   EXP_MAX         : all-ones exponent (infinity / NaN encoding)
//   FLAG_*          : bit positions inside the 4-bit flag vectors
//                     {invalid, overflow, zero, inexact}
package fp_mul_pkg;

   localparam int          EXP_W   = 8;
   localparam int          FRAC_W  = 23;
   localparam int          FLAG_W  = 4;
   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [7:0]  EXP_MAX = 8'hFF;

   localparam int FLAG_INVALID  = 3;
   localparam int FLAG_OVERFLOW = 2;
   localparam int FLAG_ZERO     = 1;
   localparam int FLAG_INEXACT  = 0;

endpackage

// File: rtl/rne_round.sv
// rne_round
// Purely combinational round-to-nearest-even of a 23-bit fraction with
// guard/round/sticky bits.
//   frac_in, exp_in          : unrounded fraction and biased exponent
//   guard, round_bit, sticky : bits below the fraction LSB
//   frac_out, exp_out        : rounded fields
//   carry_ovf                : rounded exponent reached the all-ones code
//   inexact                  : any discarded bit was set
module rne_round
   import fp_mul_pkg::*;
(
   input  logic [FRAC_W-1:0] frac_in,
   input  logic [EXP_W-1:0]  exp_in,
   input  logic              guard,
   input  logic              round_bit,
   input  logic              sticky,
   output logic [FRAC_W-1:0] frac_out,
   output logic [EXP_W-1:0]  exp_out,
   output logic              carry_ovf,
   output logic              inexact
);

   logic              round_up;
   logic [FRAC_W:0]   frac_sum;

   // A carry out of the fraction leaves the low bits zero and bumps the
   // exponent; the exponent add wraps at 8 bits by design.
   always_comb begin
      round_up  = guard & (round_bit | sticky | frac_in[0]);
      frac_sum  = {1'b0, frac_in} + {{FRAC_W{1'b0}}, round_up};
      frac_out  = frac_sum[FRAC_W] ? '0 : frac_sum[FRAC_W-1:0];
      exp_out   = exp_in + {{(EXP_W-1){1'b0}}, frac_sum[FRAC_W]};
      carry_ovf = (exp_out == EXP_MAX);
      inexact   = guard | round_bit | sticky;
   end

endmodule

// File: rtl/mul_result_pack.sv
// mul_result_pack
// Final two-stage pipeline of the FP multiplier: stage 1 captures the
// product fields, stage 2 rounds (RNE), applies exception priority and
// holds the packed IEEE-754 single result under valid/ready flow control.
//   clk, rst_n                      : clock, async active-low reset
//   in_valid/in_ready               : upstream handshake
//   sign_z, Ez, Mz_ext              : product sign, exponent, fraction+GRS
//   invalid_flag/overflow_flag/zero_flag : exception stage flags
//   out_valid/out_ready, result     : downstream handshake and result
//   flags_out                       : {invalid, overflow, zero, inexact}
//   sticky_flags, sticky_clr        : accumulated flags and their clear
// Optional feature macro: STICKY_FLAGS_EN enables the sticky flag register;
// without it sticky_flags reads 0 and sticky_clr is ignored.
module mul_result_pack
   import fp_mul_pkg::*;
#(
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              sign_z,
   input  logic [EXP_W-1:0]  Ez,
   input  logic [25:0]       Mz_ext,
   input  logic              invalid_flag,
   input  logic              overflow_flag,
   input  logic              zero_flag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       result,
   output logic [FLAG_W-1:0] flags_out,
   output logic [FLAG_W-1:0] sticky_flags,
   input  logic              sticky_clr
);

   if (LATENCY != 2) begin : g_bad_latency
      $error("mul_result_pack only supports LATENCY == 2");
   end

   logic              s1_valid;
   logic              s1_sign;
   logic [EXP_W-1:0]  s1_ez;
   logic [25:0]       s1_mz;
   logic              s1_invalid;
   logic              s1_overflow;
   logic              s1_zero;

   logic              s2_advance;
   logic              accept;

   logic [FRAC_W-1:0] rnd_frac;
   logic [EXP_W-1:0]  rnd_exp;
   logic              rnd_carry_ovf;
   logic              rnd_inexact;

   logic [31:0]       next_result;
   logic [FLAG_W-1:0] next_flags;

   assign s2_advance = !out_valid || out_ready;
   assign in_ready   = !s1_valid || s2_advance;
   assign accept     = in_valid && in_ready;

   // Stage 1 drains into stage 2 whenever stage 2 can advance, so it only
   // stays occupied when a new beat replaces it or the output is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s1_sign     <= 1'b0;
         s1_ez       <= '0;
         s1_mz       <= '0;
         s1_invalid  <= 1'b0;
         s1_overflow <= 1'b0;
         s1_zero     <= 1'b0;
      end else if (accept) begin
         s1_valid    <= 1'b1;
         s1_sign     <= sign_z;
         s1_ez       <= Ez;
         s1_mz       <= Mz_ext;
         s1_invalid  <= invalid_flag;
         s1_overflow <= overflow_flag;
         s1_zero     <= zero_flag;
      end else if (s2_advance) begin
         s1_valid    <= 1'b0;
      end
   end

   rne_round u_rne_round (
      .frac_in   (s1_mz[25:3]),
      .exp_in    (s1_ez),
      .guard     (s1_mz[2]),
      .round_bit (s1_mz[1]),
      .sticky    (s1_mz[0]),
      .frac_out  (rnd_frac),
      .exp_out   (rnd_exp),
      .carry_ovf (rnd_carry_ovf),
      .inexact   (rnd_inexact)
   );

   // Input exception flags pass straight into flags_out; inexact only
   // applies when the rounded value is actually what gets returned.
   always_comb begin
      next_flags                = '0;
      next_flags[FLAG_INVALID]  = s1_invalid;
      next_flags[FLAG_OVERFLOW] = s1_overflow;
      next_flags[FLAG_ZERO]     = s1_zero;
      if (s1_invalid) begin
         next_result = QNAN;
      end else if (s1_overflow) begin
         next_result = {s1_sign, EXP_MAX, {FRAC_W{1'b0}}};
      end else if (s1_zero) begin
         next_result = {s1_sign, 31'h0};
      end else if (rnd_carry_ovf) begin
         next_result                = {s1_sign, EXP_MAX, {FRAC_W{1'b0}}};
         next_flags[FLAG_OVERFLOW]  = 1'b1;
         next_flags[FLAG_INEXACT]   = rnd_inexact;
      end else begin
         next_result                = {s1_sign, rnd_exp, rnd_frac};
         next_flags[FLAG_INEXACT]   = rnd_inexact;
      end
   end

   // Stage 2 only updates when its current beat is consumed or empty,
   // which keeps result/flags_out frozen during a downstream stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         flags_out <= '0;
      end else if (s2_advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result    <= next_result;
            flags_out <= next_flags;
         end
      end
   end

`ifdef STICKY_FLAGS_EN
   logic [FLAG_W-1:0] sticky_q;

   // A clear coinciding with a handshake restarts accumulation from the
   // beat being handed over rather than dropping it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= '0;
      end else if (out_valid && out_ready) begin
         sticky_q <= sticky_clr ? flags_out : (sticky_q | flags_out);
      end else if (sticky_clr) begin
         sticky_q <= '0;
      end
   end

   assign sticky_flags = sticky_q;
`else
   logic unused_sticky_clr;

   assign unused_sticky_clr = sticky_clr;
   assign sticky_flags      = '0;
`endif

endmodule

// File: tb/tb_mul_result_pack.sv
// tb_mul_result_pack
// Directed self-checking bench for mul_result_pack: reset values, rounding
// and exception priority vectors, latency, sticky flags, a stalled
// four-beat stream and reset mid-stream.
module tb_mul_result_pack;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        sign_z;
   logic [7:0]  Ez;
   logic [25:0] Mz_ext;
   logic        invalid_flag;
   logic        overflow_flag;
   logic        zero_flag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  flags_out;
   logic [3:0]  sticky_flags;
   logic        sticky_clr;

   int vectors    = 0;
   int miscompares = 0;

   mul_result_pack #(.LATENCY(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .sign_z        (sign_z),
      .Ez            (Ez),
      .Mz_ext        (Mz_ext),
      .invalid_flag  (invalid_flag),
      .overflow_flag (overflow_flag),
      .zero_flag     (zero_flag),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .result        (result),
      .flags_out     (flags_out),
      .sticky_flags  (sticky_flags),
      .sticky_clr    (sticky_clr)
   );

   // 10-unit clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected sticky value depends on whether the feature is built in
   function automatic logic [3:0] stk(input logic [3:0] v);
`ifdef STICKY_FLAGS_EN
      return v;
`else
      return 4'h0 & v;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
         $error("[TB] %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one beat and hold it until accepted (bounded)
   task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [22:0] f,
                                input logic [2:0] grs, input logic inv, input logic ovf,
                                input logic zro);
      int tries;
      @(negedge clk);
      sign_z        = s;
      Ez            = e;
      Mz_ext        = {f, grs};
      invalid_flag  = inv;
      overflow_flag = ovf;
      zero_flag     = zro;
      in_valid      = 1'b1;
      tries         = 0;
      while (!in_ready && tries < 20) begin
         @(negedge clk);
         tries++;
      end
      checkOutput("accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for the result, capture it and consume it
   task automatic waitOutput(input logic clr, output logic [31:0] res,
                             output logic [3:0] flg, output int lat);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 10);
      checkOutput("out_valid_seen", 32'(out_valid), 32'd1);
      res        = result;
      flg        = flags_out;
      lat        = n;
      sticky_clr = clr;
      @(posedge clk);
      #1;
      sticky_clr = 1'b0;
   endtask

   logic [31:0] res;
   logic [3:0]  flg;
   int          lat;
   logic [31:0] expBeat [4];
   int          sent;
   int          recv;
   int          stallLeft;
   logic        take;
   logic        give;
   logic        sawValid;

   initial begin
      rst_n         = 1'b0;
      in_valid      = 1'b0;
      out_ready     = 1'b1;
      sign_z        = 1'b0;
      Ez            = 8'h00;
      Mz_ext        = 26'h0;
      invalid_flag  = 1'b0;
      overflow_flag = 1'b0;
      zero_flag     = 1'b0;
      sticky_clr    = 1'b0;

      // Reset values
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_result", result, 32'h0);
      checkOutput("rst_flags", 32'(flags_out), 32'd0);
      checkOutput("rst_sticky", 32'(sticky_flags), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1.0, exact, latency 2
      applyStimulus(1'b0, 8'h7F, 23'h000000, 3'b000, 1'b0, 1'b0, 1'b0);
      waitOutput(1'b0, res, flg, lat);
      checkOutput("one_result", res, 32'h3F800000);
      checkOutput("one_flags", 32'(flg), 32'h0);
      checkOutput("one_latency", 32'(lat), 32'd2);

      // Rounding carry from exponent FE -> infinity
      applyStimulus(1'b0, 8'hFE, 23'h7FFFFF, 3'b100, 1'b0, 1'b0, 1'b0);
      waitOutput(1'b0, res, flg, lat);
      checkOutput("carry_inf_result", res, 32'h7F800000);
      checkOutput("carry_inf_flags", 32'(flg), 32'h5);

      // Tie, odd LSB rounds up to even
      applyStimulus(1'b0, 8'h80, 23'h000001, 3'b100, 1'b0, 1'b0, 1'b0);
      waitOutput(1'b0, res, flg, lat);
      checkOutput("tie_odd_result", res, 32'h40000002);
      checkOutput("tie_odd_flags", 32'(flg), 32'h1);

      // Tie, even LSB stays
      applyStimulus(1'b0, 8'h80, 23'h000002, 3'b100, 1'b0, 1'b0, 1'b0);
      waitOutput(1'b0, res, flg, lat);
      checkOutput("tie_even_result", res, 32'h40000002);
      checkOutput("tie_even_flags", 32'(flg), 32'h1);
      checkOutput("sticky_acc1", 32'(sticky_flags), 32'(stk(4'h5)));

      // Invalid beats zero
      applyStimulus(1'b1, 8'h55, 23'h001234, 3'b111, 1'b1, 1'b0, 1'b1);
      waitOutput(1'b0, res, flg, lat);
      checkOutput("invalid_result", res, 32'h7FC00000);
      checkOutput("invalid_flags", 32'(flg), 32'hA);
      checkOutput("sticky_acc2", 32'(sticky_flags), 32'(stk(4'hF)));

      // Zero flag, negative
      applyStimulus(1'b1, 8'h40, 23'h000777, 3'b110, 1'b0, 1'b0, 1'b1);
      waitOutput(1'b0, res, flg, lat);
      checkOutput("zero_result", res, 32'h80000000);
      checkOutput("zero_flags", 32'(flg), 32'h2);

      // Round up via R bit
      applyStimulus(1'b0, 8'h81, 23'h123456, 3'b110, 1'b0, 1'b0, 1'b0);
      waitOutput(1'b0, res, flg, lat);
      checkOutput("round_r_result", res, 32'h40923457);
      checkOutput("round_r_flags", 32'(flg), 32'h1);

      // G clear: truncate but inexact
      applyStimulus(1'b0, 8'h01, 23'h7FFFFF, 3'b011, 1'b0, 1'b0, 1'b0);
      waitOutput(1'b0, res, flg, lat);
      checkOutput("trunc_result", res, 32'h00FFFFFF);
      checkOutput("trunc_flags", 32'(flg), 32'h1);

      // Fraction carry into exponent, no overflow
      applyStimulus(1'b0, 8'h7F, 23'h7FFFFF, 3'b101, 1'b0, 1'b0, 1'b0);
      waitOutput(1'b0, res, flg, lat);
      checkOutput("carry_exp_result", res, 32'h40000000);
      checkOutput("carry_exp_flags", 32'(flg), 32'h1);

      // Clear with no handshake
      @(negedge clk);
      sticky_clr = 1'b1;
      @(posedge clk);
      #1;
      sticky_clr = 1'b0;
      checkOutput("sticky_clear", 32'(sticky_flags), 32'd0);

      // Overflow beat accumulates
      applyStimulus(1'b1, 8'h10, 23'h000ABC, 3'b101, 1'b0, 1'b1, 1'b0);
      waitOutput(1'b0, res, flg, lat);
      checkOutput("ovf_result", res, 32'hFF800000);
      checkOutput("ovf_flags", 32'(flg), 32'h4);
      checkOutput("sticky_ovf", 32'(sticky_flags), 32'(stk(4'h4)));

      // Clear coincident with an inexact beat: clear wins, beat loaded
      applyStimulus(1'b0, 8'h80, 23'h000001, 3'b100, 1'b0, 1'b0, 1'b0);
      waitOutput(1'b1, res, flg, lat);
      checkOutput("clr_beat_result", res, 32'h40000002);
      checkOutput("sticky_clr_hs", 32'(sticky_flags), 32'(stk(4'h1)));

      // Four-beat stream, output stalled for 3 cycles after first handshake
      for (int i = 0; i < 4; i++) begin
         expBeat[i] = {1'b0, 8'(8'h90 + i), 23'(23'h10 + i)};
      end
      sent      = 0;
      recv      = 0;
      stallLeft = 0;
      for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
         @(negedge clk);
         out_ready = (stallLeft == 0);
         if (sent < 4) begin
            sign_z        = 1'b0;
            Ez            = 8'(8'h90 + sent);
            Mz_ext        = {23'(23'h10 + sent), 3'b000};
            invalid_flag  = 1'b0;
            overflow_flag = 1'b0;
            zero_flag     = 1'b0;
            in_valid      = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         checkOutput("stall_in_ready", 32'(in_ready), 32'((sent - recv) < 2 || out_ready));
         if (out_valid) begin
            checkOutput("stall_result", result, expBeat[recv]);
         end
         take = in_valid && in_ready;
         give = out_valid && out_ready;
         @(posedge clk);
         if (take) sent++;
         if (give) begin
            recv++;
            if (recv == 1) stallLeft = 3;
         end else if (!out_ready && stallLeft > 0) begin
            stallLeft--;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkOutput("stream_count", 32'(recv), 32'd4);
      @(negedge clk);
      checkOutput("stream_drained", 32'(out_valid), 32'd0);

      // Reset mid-stream
      applyStimulus(1'b0, 8'h20, 23'h000003, 3'b000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_result", result, 32'h0);
      checkOutput("mid_rst_flags", 32'(flags_out), 32'd0);
      checkOutput("mid_rst_sticky", 32'(sticky_flags), 32'd0);
      checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      sawValid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) sawValid = 1'b1;
      end
      checkOutput("post_rst_no_beat", 32'(sawValid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
